// File: rtl/lockstep_count_ctrl.sv
// Sequencer for a duplicated up-counter pair: clear, count to target, compare every
// cycle, resync on disagreement and latch a fault once the retry budget is spent.
module lockstep_count_ctrl #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RW        = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] target,
  input  logic             fault_ack,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             fault,
  output logic [RW-1:0]    retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_RESYNC = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             clr_q, clr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             mism_q, mism_d;
  logic             eq;
  logic             at_tgt;

  assign eq     = (cnt_a == cnt_b);
  assign at_tgt = (cnt_a == tgt_q);

  // Enable is combinational so the pair halts exactly on the target value.
  assign cnt_en = (state_q == S_RUN) && eq && !at_tgt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      retry_q <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      retry_q <= retry_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      mism_q  <= mism_d;
    end
  end

  // Next state plus registered outputs decoded from the upcoming state.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    retry_d = retry_q;
    mism_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          tgt_d   = target;
          retry_d = '0;
        end
      end
      S_CLEAR, S_RESYNC: state_d = S_RUN;
      S_RUN: begin
        if (!eq) begin
          mism_d = 1'b1;
          if (retry_q == RW'(MAX_RETRY)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RESYNC;
            retry_d = RW'(retry_q + RW'(1));
          end
        end else if (at_tgt) begin
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_FAULT: begin
        if (fault_ack) begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    clr_d   = (state_d == S_CLEAR) || (state_d == S_RESYNC);
    busy_d  = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_RESYNC);
    done_d  = (state_d == S_DONE);
    fault_d = (state_d == S_FAULT);
  end

  assign cnt_clr   = clr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign mismatch  = mism_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_lockstep_count_ctrl.sv
// Bench for lockstep_count_ctrl: per-run expected timelines are built from the run
// rules (target, glitch positions, retry budget) and replayed cycle by cycle.
module tb_lockstep_count_ctrl;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned RW        = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] target = '0;
  logic             fault_ack = 1'b0;
  logic             inj = 1'b0;
  logic [WIDTH-1:0] ca = '0;
  logic [WIDTH-1:0] cb = '0;
  logic [WIDTH-1:0] cnt_b_w;
  logic             cnt_en, cnt_clr, busy, done, mismatch, fault;
  logic [RW-1:0]    retry_cnt;

  assign cnt_b_w = inj ? WIDTH'(cb + WIDTH'(1)) : cb;

  lockstep_count_ctrl #(.WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .RW(RW)) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .fault_ack(fault_ack),
    .cnt_a(ca), .cnt_b(cnt_b_w), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy),
    .done(done), .mismatch(mismatch), .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Duplicated counter datapath; clear wins over enable.
  always @(posedge clk) begin
    if (cnt_clr) begin
      ca <= '0;
      cb <= '0;
    end else if (cnt_en) begin
      ca <= WIDTH'(ca + WIDTH'(1));
      cb <= WIDTH'(cb + WIDTH'(1));
    end
  end

  typedef struct {
    logic rst, start, fack, inj;
    logic [WIDTH-1:0] tgt;
    logic chk, chk_cnt;
    logic en, clr, busy, done, mism, fault;
    int   retry;
    int   cnt;
  } ent_t;

  ent_t sched[$];
  int   cur_retry = 0;
  int   glit[0:MAX_RETRY];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic ent_t blank();
    ent_t e;
    e.rst = 1'b0; e.start = 1'b0; e.fack = 1'b0; e.inj = 1'b0;
    e.tgt = WIDTH'($urandom);
    e.chk = 1'b1; e.chk_cnt = 1'b0;
    e.en = 1'b0; e.clr = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.mism = 1'b0; e.fault = 1'b0;
    e.retry = cur_retry;
    e.cnt = 0;
    return e;
  endfunction

  task automatic add_idle(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = blank();
      e.fack = 1'($urandom);
      sched.push_back(e);
    end
  endtask

  // Expected timeline of one run; glit[a] is the count value glitched in attempt a, -1 for none.
  task automatic add_run(input int t, output bit faulted);
    ent_t e;
    int   att;
    int   c;
    faulted = 1'b0;
    e = blank(); e.start = 1'b1; e.tgt = WIDTH'(t);
    sched.push_back(e);
    cur_retry = 0;
    e = blank(); e.clr = 1'b1; e.busy = 1'b1; e.start = 1'($urandom);
    sched.push_back(e);
    att = 0;
    c = 0;
    forever begin
      e = blank(); e.busy = 1'b1; e.chk_cnt = 1'b1; e.cnt = c;
      e.start = 1'($urandom); e.fack = 1'($urandom);
      if (att <= int'(MAX_RETRY) && glit[att] == c) begin
        e.inj = 1'b1;
        sched.push_back(e);
        if (cur_retry == int'(MAX_RETRY)) begin
          e = blank(); e.fault = 1'b1; e.mism = 1'b1;
          sched.push_back(e);
          faulted = 1'b1;
          return;
        end
        cur_retry++;
        e = blank(); e.clr = 1'b1; e.busy = 1'b1; e.mism = 1'b1; e.start = 1'($urandom);
        sched.push_back(e);
        att++;
        c = 0;
      end else if (c == t) begin
        sched.push_back(e);
        e = blank(); e.done = 1'b1; e.start = 1'($urandom);
        sched.push_back(e);
        return;
      end else begin
        e.en = 1'b1;
        sched.push_back(e);
        c++;
      end
    end
  endtask

  task automatic add_fault_hold(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = blank(); e.fault = 1'b1; e.start = 1'($urandom);
      sched.push_back(e);
    end
    e = blank(); e.fault = 1'b1; e.fack = 1'b1; e.start = 1'b1;
    sched.push_back(e);
    cur_retry = 0;
    add_idle(1);
  endtask

  // Truncate the timeline with reset asserted at relative cycle k of the run starting at base.
  task automatic cut_with_reset(input int base, input int k);
    sched[base + k].rst = 1'b1;
    while (sched.size() > base + k + 1) void'(sched.pop_back());
    cur_retry = 0;
    add_idle(1);
  endtask

  task automatic no_glitch();
    for (int i = 0; i <= int'(MAX_RETRY); i++) glit[i] = -1;
  endtask

  initial begin
    ent_t e;
    bit   f;
    int   base;
    e = blank(); e.rst = 1'b1; e.chk = 1'b0; sched.push_back(e);
    e = blank(); e.rst = 1'b1; e.chk = 1'b0; sched.push_back(e);
    add_idle(2);

    no_glitch(); add_run(5, f); add_idle(2);
    no_glitch(); add_run(0, f); add_idle(1);
    no_glitch(); glit[0] = 3; add_run(9, f); add_idle(1);
    no_glitch(); glit[0] = 2; glit[1] = 0; glit[2] = 5; glit[3] = 1;
    add_run(7, f); add_fault_hold(4);
    no_glitch(); add_run(2, f); add_idle(1);
    no_glitch(); base = sched.size(); add_run(12, f); cut_with_reset(base, 8);
    no_glitch(); add_run(3, f); add_idle(1);
    no_glitch(); add_run(15, f);

    for (int r = 0; r < 40; r++) begin
      int t;
      t = int'($urandom_range(15, 0));
      no_glitch();
      for (int a = 0; a <= int'(MAX_RETRY); a++)
        if ($urandom_range(9, 0) < 4) glit[a] = int'($urandom_range(t, 0));
      base = sched.size();
      add_run(t, f);
      if (f) add_fault_hold(int'($urandom_range(3, 0)));
      else if ($urandom_range(7, 0) == 0) cut_with_reset(base, int'($urandom_range(sched.size() - base - 1, 1)));
      add_idle(int'($urandom_range(2, 0)));
    end

    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      reset = sched[i].rst; start = sched[i].start; target = sched[i].tgt;
      fault_ack = sched[i].fack; inj = sched[i].inj;
      #1;
      if (sched[i].chk) begin
        check("cnt_en", i, 32'(cnt_en), 32'(sched[i].en));
        check("cnt_clr", i, 32'(cnt_clr), 32'(sched[i].clr));
        check("busy", i, 32'(busy), 32'(sched[i].busy));
        check("done", i, 32'(done), 32'(sched[i].done));
        check("mismatch", i, 32'(mismatch), 32'(sched[i].mism));
        check("fault", i, 32'(fault), 32'(sched[i].fault));
        check("retry_cnt", i, 32'(retry_cnt), 32'(sched[i].retry));
        if (sched[i].chk_cnt) check("cnt_a", i, 32'(ca), 32'(sched[i].cnt));
      end
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lockstep_count_ctrl.md
Name: lockstep_count_ctrl

Overview:
- Controller that sequences a redundant (lockstep) pair of WIDTH-bit up-counters.
- On request it clears both counters, then enables them together until they reach a programmed target.
- It checks the pair every cycle. On disagreement it re-clears and retries, and it latches a fault after too many disagreements.
- Sits between the requesting logic and the duplicated counter/comparator datapath. It replaces ad-hoc clock gating with explicit enable/clear sequencing.

Parameters:
- WIDTH, 4: bit width of the counters and the target.
- MAX_RETRY, 3: number of resync attempts allowed per run; the (MAX_RETRY+1)th mismatch faults.
- RW, 2: width of retry_cnt; must satisfy 2^RW > MAX_RETRY.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: run request, sampled only in IDLE.
- target, input, WIDTH: terminal count, captured into tgt_q when start is accepted.
- fault_ack, input, 1: clears the FAULT state.
- cnt_a, input, WIDTH: registered value of counter A.
- cnt_b, input, WIDTH: registered value of counter B.
- cnt_en, output, 1: increment enable to both counters (combinational).
- cnt_clr, output, 1: synchronous clear to both counters.
- busy, output, 1: high in CLEAR, RUN or RESYNC.
- done, output, 1: one-cycle pulse on successful completion.
- mismatch, output, 1: one-cycle pulse per detected disagreement.
- fault, output, 1: high in FAULT.
- retry_cnt, output, RW: number of resyncs in the current run.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: next state IDLE; tgt_q=0, retry_cnt=0. All outputs 0: cnt_en, cnt_clr, busy, done, mismatch, fault.
- Counters are assumed to clear or increment on the edge where cnt_clr or cnt_en is sampled high; clr has priority.
- States: IDLE, CLEAR, RUN, RESYNC, DONE, FAULT.
- IDLE:
  - All outputs low.
  - start=1 -> CLEAR; tgt_q<=target; retry_cnt<=0.
- CLEAR:
  - cnt_clr=1, busy=1, for exactly one cycle -> RUN.
- RUN:
  - busy=1; eq = (cnt_a==cnt_b).
  - cnt_en = eq && (cnt_a != tgt_q). This is combinational, so the counters stop exactly at target with no overshoot.
  - Priority 1, !eq:
    - If retry_cnt==MAX_RETRY -> FAULT.
    - Else -> RESYNC, with retry_cnt<=retry_cnt+1.
  - Priority 2, eq && cnt_a==tgt_q -> DONE.
  - Otherwise stay in RUN.
- RESYNC:
  - cnt_clr=1, busy=1, one cycle -> RUN. The count restarts from 0 and tgt_q is kept.
- DONE:
  - done=1 for one cycle -> IDLE.
  - start is ignored in the DONE cycle.
- FAULT:
  - fault=1; cnt_en=0, cnt_clr=0.
  - Held until fault_ack=1 -> IDLE, with retry_cnt<=0.
  - start is ignored, including when it arrives together with fault_ack.
- mismatch: registered, high in the cycle after every RUN cycle with !eq, including the fatal one.
- Latency, no mismatches, start high in cycle 0:
  - cycle 1 CLEAR;
  - cycles 2..T+2 RUN, with cnt=0..T;
  - done high in cycle T+3.
- Boundaries:
  - target=0 -> done in cycle 3 and cnt_en is never asserted.
  - target=2^WIDTH-1 -> the counters never wrap.
- start outside IDLE is ignored; fault_ack outside FAULT is ignored.
- Reset mid-run -> IDLE on the next edge with no cnt_clr pulse. The next start clears the counters.
- retry_cnt saturates at MAX_RETRY.

Test Plan:
- Nominal run: reset, then start with target=5 and the counters tracking. Required: cnt_clr in cycle 1; cnt_en high for exactly 5 cycles; done in cycle 8; final cnt_a=cnt_b=5; retry_cnt=0.
- Zero target: start with target=0. Required: cnt_en never high; done in cycle 3; busy high in cycles 1–2 only.
- Single glitch: target=9; force cnt_b off by one for one cycle at cnt=3. Required: cnt_en low that cycle; mismatch pulse next cycle; cnt_clr in RESYNC; retry_cnt=1; run restarts from 0; done after a further 10 RUN cycles.
- Fault: MAX_RETRY=3; inject 4 separate mismatches. Required: 3 RESYNC cnt_clr pulses; 4 mismatch pulses; fault=1 and held; start ignored; fault_ack -> IDLE with retry_cnt=0; a following start with target=2 completes normally.
- Mid-run reset: start with target=12; assert reset at cnt=6. Required: next cycle all outputs 0 and state IDLE; no cnt_clr; a following start gives cnt_clr then a normal completion.
- Ignored requests: pulse start in RUN and DONE, pulse fault_ack in RUN. Required: no change to tgt_q, state or outputs.
